// File: rtl/tail_light_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tail_light_pkg : lamp patterns, decoder states and mode encoding      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tail_light_pkg;

    // Lamp bus patterns, [5:3] left lamps and [2:0] right lamps
    localparam logic [5:0] c_off = 6'b000000;
    localparam logic [5:0] c_l1  = 6'b001000;
    localparam logic [5:0] c_l2  = 6'b011000;
    localparam logic [5:0] c_l3  = 6'b111000;
    localparam logic [5:0] c_r1  = 6'b000100;
    localparam logic [5:0] c_r2  = 6'b000110;
    localparam logic [5:0] c_r3  = 6'b000111;
    localparam logic [5:0] c_h1  = 6'b001100;
    localparam logic [5:0] c_h2  = 6'b011110;
    localparam logic [5:0] c_h3  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SL1  = 3'd1,
        ST_SL2  = 3'd2,
        ST_SR1  = 3'd3,
        ST_SR2  = 3'd4,
        ST_SH1  = 3'd5,
        ST_SH2  = 3'd6,
        ST_TAIL = 3'd7
    } dec_state_t;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    // Where a pattern seen from IDLE leads; also used to resynchronise after an error
    function automatic dec_state_t idle_decode(input logic [5:0] pat);
        dec_state_t s;
        s = ST_IDLE;
        if (pat == c_l1)      s = ST_SL1;
        else if (pat == c_r1) s = ST_SR1;
        else if (pat == c_h1) s = ST_SH1;
        return s;
    endfunction

    function automatic mode_t state_mode(input dec_state_t s);
        mode_t m;
        case (s)
            ST_SL1, ST_SL2: m = MODE_LEFT;
            ST_SR1, ST_SR2: m = MODE_RIGHT;
            ST_SH1, ST_SH2: m = MODE_HAZ;
            default:        m = MODE_NONE;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_decoder_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : W-bit event counter saturating at all-ones, sync clear  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tail_light_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tail_light_decoder : checks the lamp bus against left/right/hazard    |
// | sequences, pulses completions and errors, keeps saturating counts     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       lights,
    input  logic             clr,
    output logic [1:0]       mode,
    output logic             left_done,
    output logic             right_done,
    output logic             haz_done,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] haz_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    dec_state_t r_state;
    dec_state_t w_next;
    logic       w_left;
    logic       w_right;
    logic       w_haz;
    logic       w_err;

    always_comb begin
        w_next  = r_state;
        w_left  = 1'b0;
        w_right = 1'b0;
        w_haz   = 1'b0;
        w_err   = 1'b0;
        if (valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (lights == c_off || lights == c_l1 ||
                        lights == c_r1  || lights == c_h1) w_next = idle_decode(lights);
                    else                                  w_err  = 1'b1;
                end
                ST_SL1:  if (lights == c_l2) w_next = ST_SL2; else w_err = 1'b1;
                ST_SL2:  if (lights == c_l3) begin w_next = ST_TAIL; w_left = 1'b1; end
                         else w_err = 1'b1;
                ST_SR1:  if (lights == c_r2) w_next = ST_SR2; else w_err = 1'b1;
                ST_SR2:  if (lights == c_r3) begin w_next = ST_TAIL; w_right = 1'b1; end
                         else w_err = 1'b1;
                ST_SH1:  if (lights == c_h2) w_next = ST_SH2; else w_err = 1'b1;
                ST_SH2:  if (lights == c_h3) begin w_next = ST_TAIL; w_haz = 1'b1; end
                         else w_err = 1'b1;
                ST_TAIL: if (lights == c_off) w_next = ST_IDLE; else w_err = 1'b1;
                default: w_err = 1'b1;
            endcase
            // The offending sample may itself be the first step of a new sequence
            if (w_err) w_next = idle_decode(lights);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            mode       <= MODE_NONE;
            left_done  <= 1'b0;
            right_done <= 1'b0;
            haz_done   <= 1'b0;
            err_pulse  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            r_state    <= w_next;
            mode       <= state_mode(w_next);
            left_done  <= w_left;
            right_done <= w_right;
            haz_done   <= w_haz;
            err_pulse  <= w_err;
            err_flag   <= clr ? 1'b0 : (err_flag | w_err);
        end
    end

    sat_counter #(.W(CNT_W)) u_left_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(w_left), .q(left_cnt)
    );

    sat_counter #(.W(CNT_W)) u_right_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(w_right), .q(right_cnt)
    );

    sat_counter #(.W(CNT_W)) u_haz_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(w_haz), .q(haz_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(w_err), .q(err_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_tail_light_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tail_light_decoder : directed vectors with a queued scoreboard     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tail_light_decoder;

    localparam int CNT_W = 2;

    localparam logic [5:0] OFF = 6'b000000;
    localparam logic [5:0] L1  = 6'b001000;
    localparam logic [5:0] L2  = 6'b011000;
    localparam logic [5:0] L3  = 6'b111000;
    localparam logic [5:0] R1  = 6'b000100;
    localparam logic [5:0] R2  = 6'b000110;
    localparam logic [5:0] R3  = 6'b000111;
    localparam logic [5:0] H1  = 6'b001100;
    localparam logic [5:0] H2  = 6'b011110;
    localparam logic [5:0] H3  = 6'b111111;

    // Pulse field order: left_done, right_done, haz_done, err_pulse
    localparam logic [3:0] PN = 4'b0000;
    localparam logic [3:0] PL = 4'b1000;
    localparam logic [3:0] PR = 4'b0100;
    localparam logic [3:0] PH = 4'b0010;
    localparam logic [3:0] PE = 4'b0001;

    localparam logic [1:0] M0 = 2'b00;
    localparam logic [1:0] ML = 2'b01;
    localparam logic [1:0] MR = 2'b10;
    localparam logic [1:0] MH = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [5:0]       lights;
    logic             clr;
    logic [1:0]       mode;
    logic             left_done, right_done, haz_done, err_pulse, err_flag;
    logic [CNT_W-1:0] left_cnt, right_cnt, haz_cnt, err_cnt;

    always #5 clk = ~clk;

    tail_light_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid(valid), .lights(lights), .clr(clr),
        .mode(mode), .left_done(left_done), .right_done(right_done),
        .haz_done(haz_done), .err_pulse(err_pulse), .err_flag(err_flag),
        .left_cnt(left_cnt), .right_cnt(right_cnt), .haz_cnt(haz_cnt),
        .err_cnt(err_cnt)
    );

    logic [14:0] exp_q[$];
    int          id_q[$];
    int          vec_no = 0;
    int          checks = 0;
    int          errors = 0;

    // Drive one sample and queue the outputs expected after the next rising edge
    task automatic v(input logic r, input logic va, input logic [5:0] l, input logic c,
                     input logic [1:0] m, input logic [3:0] p, input logic ef,
                     input logic [1:0] lc, input logic [1:0] rc,
                     input logic [1:0] hc, input logic [1:0] ec);
        @(negedge clk);
        reset  = r;
        valid  = va;
        lights = l;
        clr    = c;
        exp_q.push_back({m, p, ef, lc, rc, hc, ec});
        id_q.push_back(vec_no);
        vec_no++;
    endtask

    initial begin : monitor
        logic [14:0] e;
        logic [14:0] a;
        int          id;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                a  = {mode, left_done, right_done, haz_done, err_pulse, err_flag,
                      left_cnt, right_cnt, haz_cnt, err_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL vec%0d: got mode=%b ld/rd/hd/ep=%b ef=%b cnt l/r/h/e=%0d/%0d/%0d/%0d, expected mode=%b ld/rd/hd/ep=%b ef=%b cnt l/r/h/e=%0d/%0d/%0d/%0d",
                             id, a[14:13], a[12:9], a[8], a[7:6], a[5:4], a[3:2], a[1:0],
                             e[14:13], e[12:9], e[8], e[7:6], e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; valid = 1'b0; lights = OFF; clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with garbage on the bus, then idle OFF samples
        v(1, 1, 6'b101010, 0, M0, PN, 0, 0, 0, 0, 0);
        v(1, 1, H3,        0, M0, PN, 0, 0, 0, 0, 0);
        v(0, 1, OFF,       0, M0, PN, 0, 0, 0, 0, 0);
        v(0, 1, OFF,       0, M0, PN, 0, 0, 0, 0, 0);

        // Left sequence
        v(0, 1, L1,  0, ML, PN, 0, 0, 0, 0, 0);
        v(0, 1, L2,  0, ML, PN, 0, 0, 0, 0, 0);
        v(0, 1, L3,  0, M0, PL, 0, 1, 0, 0, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 1, 0, 0, 0);

        // Two right sequences and one hazard
        v(0, 1, R1,  0, MR, PN, 0, 1, 0, 0, 0);
        v(0, 1, R2,  0, MR, PN, 0, 1, 0, 0, 0);
        v(0, 1, R3,  0, M0, PR, 0, 1, 1, 0, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 1, 1, 0, 0);
        v(0, 1, R1,  0, MR, PN, 0, 1, 1, 0, 0);
        v(0, 1, R2,  0, MR, PN, 0, 1, 1, 0, 0);
        v(0, 1, R3,  0, M0, PR, 0, 1, 2, 0, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 1, 2, 0, 0);
        v(0, 1, H1,  0, MH, PN, 0, 1, 2, 0, 0);
        v(0, 1, H2,  0, MH, PN, 0, 1, 2, 0, 0);
        v(0, 1, H3,  0, M0, PH, 0, 1, 2, 1, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 1, 2, 1, 0);

        // Clear, then errors with resynchronisation
        v(0, 1, OFF, 1, M0, PN, 0, 0, 0, 0, 0);
        v(0, 1, L1,  0, ML, PN, 0, 0, 0, 0, 0);
        v(0, 1, R2,  0, M0, PE, 1, 0, 0, 0, 1);
        v(0, 1, R1,  0, MR, PN, 1, 0, 0, 0, 1);
        v(0, 1, R2,  0, MR, PN, 1, 0, 0, 0, 1);
        v(0, 1, R3,  0, M0, PR, 1, 0, 1, 0, 1);
        v(0, 1, OFF, 0, M0, PN, 1, 0, 1, 0, 1);
        v(0, 1, L1,  0, ML, PN, 1, 0, 1, 0, 1);
        v(0, 1, L2,  0, ML, PN, 1, 0, 1, 0, 1);
        v(0, 1, L3,  0, M0, PL, 1, 1, 1, 0, 1);
        v(0, 1, L1,  0, ML, PE, 1, 1, 1, 0, 2);

        // valid=0 holds everything while the bus carries junk
        v(0, 0, H3,        0, ML, PN, 1, 1, 1, 0, 2);
        v(0, 0, 6'b010101, 0, ML, PN, 1, 1, 1, 0, 2);
        v(0, 0, L2,        0, ML, PN, 1, 1, 1, 0, 2);
        v(0, 1, L2,        0, ML, PN, 1, 1, 1, 0, 2);
        v(0, 1, L3,        0, M0, PL, 1, 2, 1, 0, 2);
        v(0, 1, OFF,       0, M0, PN, 1, 2, 1, 0, 2);

        // Saturation at 3 for a 2-bit counter
        v(0, 1, OFF, 1, M0, PN, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] c;
            c = (i > 3) ? 2'd3 : 2'(i);
            v(0, 1, L1,  0, ML, PN, 0, c - ((i > 3) ? 2'd0 : 2'd1), 0, 0, 0);
            v(0, 1, L2,  0, ML, PN, 0, c - ((i > 3) ? 2'd0 : 2'd1), 0, 0, 0);
            v(0, 1, L3,  0, M0, PL, 0, c, 0, 0, 0);
            v(0, 1, OFF, 0, M0, PN, 0, c, 0, 0, 0);
        end

        // clr coincident with a completion, then with an error
        v(0, 1, L1,  0, ML, PN, 0, 3, 0, 0, 0);
        v(0, 1, L2,  0, ML, PN, 0, 3, 0, 0, 0);
        v(0, 1, L3,  1, M0, PL, 0, 0, 0, 0, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 0, 0, 0, 0);
        v(0, 1, L2,  1, M0, PE, 0, 0, 0, 0, 0);
        v(0, 1, OFF, 0, M0, PN, 0, 0, 0, 0, 0);

        // Reset mid-sequence; the stale step afterwards is an error
        v(0, 1, L1,  0, ML, PN, 0, 0, 0, 0, 0);
        v(0, 1, L2,  0, ML, PN, 0, 0, 0, 0, 0);
        v(1, 1, L2,  0, M0, PN, 0, 0, 0, 0, 0);
        v(0, 1, L3,  0, M0, PE, 1, 0, 0, 0, 1);

        // Hazard abort, repeated step, and error counter saturation
        v(0, 1, H1,  0, MH, PN, 1, 0, 0, 0, 1);
        v(0, 1, OFF, 0, M0, PE, 1, 0, 0, 0, 2);
        v(0, 1, R1,  0, MR, PN, 1, 0, 0, 0, 2);
        v(0, 1, R1,  0, MR, PE, 1, 0, 0, 0, 3);
        v(0, 1, R1,  0, MR, PE, 1, 0, 0, 0, 3);
        v(0, 1, OFF, 0, M0, PE, 1, 0, 0, 0, 3);
        v(0, 1, OFF, 0, M0, PN, 1, 0, 0, 0, 3);

        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
